// File: rtl/delta_decimator.sv
// Delta-modulator decimator: averages windows of 2^DECIM_LOG2 tracking codes and
// flags clipping, slope overload and unacknowledged-result overruns.
module delta_decimator #(
  parameter int unsigned DECIM_LOG2 = 4,
  parameter int unsigned OVL_RUN    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] code,
  output logic [7:0] sample,
  output logic       sample_valid,
  input  logic       sample_ack,
  output logic       clip,
  output logic       overload,
  output logic       overrun
);

  localparam int unsigned AccW = 8 + DECIM_LOG2;

  typedef enum logic [1:0] {DirFlat, DirUp, DirDown} dir_e;

  logic [AccW-1:0]       acc_q, acc_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]            prev_q, prev_d;
  logic                  prev_vld_q, prev_vld_d;
  dir_e                  dir_q, dir_d;
  logic [7:0]            run_q, run_d;
  logic                  win_clip_q, win_clip_d;
  logic [7:0]            sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  clip_q, clip_d;
  logic                  overrun_q, overrun_d;

  logic [AccW-1:0] sum;
  logic            done;
  logic            code_clip;
  dir_e            cur_dir;

  always_comb begin
    sum       = acc_q + AccW'(code);
    done      = en && (cnt_q == '1);
    code_clip = (code == 8'h00) || (code == 8'hFF);
    if (code > prev_q) begin
      cur_dir = DirUp;
    end else if (code < prev_q) begin
      cur_dir = DirDown;
    end else begin
      cur_dir = DirFlat;
    end
  end

  // Window accumulation and result hand-off.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    win_clip_d = win_clip_q;
    sample_d   = sample_q;
    valid_d    = valid_q;
    clip_d     = clip_q;
    overrun_d  = overrun_q;

    if (en) begin
      if (done) begin
        acc_d      = '0;
        cnt_d      = '0;
        win_clip_d = 1'b0;
        sample_d   = 8'(sum >> DECIM_LOG2);
        clip_d     = win_clip_q | code_clip;
      end else begin
        acc_d      = sum;
        cnt_d      = cnt_q + DECIM_LOG2'(1);
        win_clip_d = win_clip_q | code_clip;
      end
    end

    if (done) begin
      valid_d = 1'b1;
      if (valid_q && !sample_ack) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && sample_ack) begin
      valid_d = 1'b0;
    end
  end

  // Slope tracking; the first code after reset only seeds prev.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    dir_d      = dir_q;
    run_d      = run_q;

    if (en) begin
      prev_d     = code;
      prev_vld_d = 1'b1;
      if (prev_vld_q) begin
        if (cur_dir == DirFlat) begin
          run_d = 8'd0;
          dir_d = DirFlat;
        end else if (cur_dir == dir_q) begin
          if (run_q < 8'(OVL_RUN)) begin
            run_d = run_q + 8'd1;
          end
        end else begin
          run_d = 8'd1;
          dir_d = cur_dir;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      dir_q      <= DirFlat;
      run_q      <= '0;
      win_clip_q <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      dir_q      <= dir_d;
      run_q      <= run_d;
      win_clip_q <= win_clip_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;
  assign overrun      = overrun_q;
  assign overload     = (run_q >= 8'(OVL_RUN));

endmodule

// File: tb/tb_delta_decimator.sv
// Directed and randomized bench for delta_decimator, compared each cycle against a
// window-queue reference model.
module tb_delta_decimator;

  localparam int unsigned DL  = 4;
  localparam int unsigned OVL = 8;
  localparam int          WIN = 1 << DL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] code = 8'd0;
  logic       sample_ack = 1'b0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       clip;
  logic       overload;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int win[$];
  int m_sample, m_valid, m_clip, m_overrun;
  int prev, dir, run;

  delta_decimator #(
    .DECIM_LOG2(DL),
    .OVL_RUN   (OVL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .code        (code),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ack  (sample_ack),
    .clip        (clip),
    .overload    (overload),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_sample = 0; m_valid = 0; m_clip = 0; m_overrun = 0;
    prev = -1; dir = 0; run = 0;
  endtask

  task automatic model_step(input bit e, input int c, input bit a);
    bit done = 0;
    int sum, d;
    bit cl;
    if (e) begin
      win.push_back(c);
      if (win.size() == WIN) begin
        sum = 0; cl = 0;
        foreach (win[i]) begin
          sum += win[i];
          if (win[i] == 0 || win[i] == 255) cl = 1;
        end
        m_sample = sum / WIN;
        m_clip   = cl;
        done     = 1;
        win.delete();
      end
      if (prev >= 0) begin
        d = (c > prev) ? 1 : (c < prev) ? -1 : 0;
        if (d == 0) begin
          run = 0; dir = 0;
        end else if (d == dir) begin
          if (run < OVL) run++;
        end else begin
          run = 1; dir = d;
        end
      end
      prev = c;
    end
    if (done) begin
      if (m_valid == 1 && !a) m_overrun = 1;
      m_valid = 1;
    end else if (m_valid == 1 && a) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sample"},   int'(sample),       m_sample);
    chk({tag, ".valid"},    int'(sample_valid), m_valid);
    chk({tag, ".clip"},     int'(clip),         m_clip);
    chk({tag, ".overload"}, int'(overload),     (run >= OVL) ? 1 : 0);
    chk({tag, ".overrun"},  int'(overrun),      m_overrun);
  endtask

  task automatic step(input bit e, input int c, input bit a, input string tag);
    @(negedge clk);
    en = e; code = 8'(c); sample_ack = a;
    @(posedge clk);
    model_step(e, c, a);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; sample_ack = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int gap;
    int rc;
    model_reset();

    // Reset state
    do_reset();

    // Constant 100 window
    for (int i = 0; i < WIN; i++) step(1, 100, 0, "const100");
    chk("const100.final_sample", int'(sample), 100);
    chk("const100.final_valid", int'(sample_valid), 1);

    // Ramp 0..15 with overload
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      step(1, i, 0, "ramp");
      if (i == 7) chk("ramp.overload_pre", int'(overload), 0);
      if (i == 8) chk("ramp.overload_rise", int'(overload), 1);
    end
    chk("ramp.sample", int'(sample), 7);
    chk("ramp.clip", int'(clip), 1);

    // Overrun with ack held low
    do_reset();
    for (int i = 0; i < 2 * WIN; i++) step(1, 50, 0, "ovr50");
    chk("ovr.flag_after_2nd", int'(overrun), 1);
    for (int i = 0; i < WIN; i++) step(1, 60, 0, "ovr60");
    chk("ovr.sample60", int'(sample), 60);
    chk("ovr.valid_held", int'(sample_valid), 1);

    // Ack coincident with completion, then ack on next cycle
    do_reset();
    for (int i = 0; i < WIN; i++) step(1, 50, 0, "ackc_a");
    for (int i = 0; i < WIN - 1; i++) step(1, 70, 0, "ackc_b");
    step(1, 70, 1, "ackc_edge");
    chk("ackc.sample", int'(sample), 70);
    chk("ackc.valid", int'(sample_valid), 1);
    chk("ackc.overrun", int'(overrun), 0);
    step(0, 0, 1, "ackc_drop");
    chk("ackc.valid_drop", int'(sample_valid), 0);
    step(0, 0, 1, "ack_idle");

    // Reset mid-window discards partial data
    for (int i = 0; i < 10; i++) step(1, 255, 0, "pre_rst");
    do_reset();
    for (int i = 0; i < WIN; i++) step(1, 200, 0, "post_rst");
    chk("post_rst.sample", int'(sample), 200);
    chk("post_rst.clip", int'(clip), 0);
    chk("post_rst.overrun", int'(overrun), 0);

    // en gaps inside a window
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(0, $urandom_range(0, 255), 0, "gap_idle");
      step(1, 30, 0, "gap_en");
    end
    chk("gap.sample", int'(sample), 30);

    // Random traffic: mixture of ramps, extremes and noise
    do_reset();
    rc = 128;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rc = ($urandom_range(0, 1) != 0) ? 255 : 0;
        1: rc = $urandom_range(0, 255);
        default: begin
          rc = rc + 3;
          if (rc > 255) rc = 0;
        end
      endcase
      step($urandom_range(0, 4) != 0, rc, $urandom_range(0, 5) == 0, "rand");
      if (i == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_decimator.md
DELTA_DECIMATOR -- requirements
Module: delta_decimator

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 4; log2 of the window length in samples, legal range 1..8.
REQ-002 SHALL have parameter OVL_RUN, default 8; number of consecutive same-direction steps that flags slope overload, legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  sample-accept strobe; code is taken on each rising edge where en=1.
REQ-006 SHALL have port code  input  8  unsigned tracking code from the delta modulator stage.
REQ-007 SHALL have port sample  output  8  decimated (window-averaged) result.
REQ-008 SHALL have port sample_valid  output  1  result-pending flag, held until acknowledged.
REQ-009 SHALL have port sample_ack  input  1  consumer acknowledge of the pending result.
REQ-010 SHALL have port clip  output  1  the window behind the current sample contained a code of 0 or 255.
REQ-011 SHALL have port overload  output  1  live slope-overload indicator.
REQ-012 SHALL have port overrun  output  1  sticky flag: an unacknowledged result was overwritten.

Function
REQ-013 SHALL keep a (8+DECIM_LOG2)-bit accumulator and a DECIM_LOG2-bit sample counter; these SHALL never overflow.
REQ-014 On an edge with en=1, the block SHALL add code to the accumulator and increment the counter; with en=0, the accumulator, counter, previous-code and run state SHALL hold.
REQ-015 On the edge accepting the 2^DECIM_LOG2-th sample (counter all-ones, en=1), the block SHALL load sample with (accumulator+code)>>DECIM_LOG2, truncating, and clear the accumulator and counter to 0.
REQ-016 Latency: sample and sample_valid SHALL update at the same edge that accepts the last sample of the window; both are visible in the following cycle.
REQ-017 sample_valid SHALL rise on a window completion and fall on the first edge where sample_valid=1 and sample_ack=1 with no completion on that edge.
REQ-018 sample_ack while sample_valid=0 SHALL be ignored.
REQ-019 Completion with sample_valid=1 and sample_ack=0 SHALL overwrite sample, keep sample_valid=1 and set overrun.
REQ-020 Completion with sample_valid=1 and sample_ack=1 on the same edge SHALL load the new sample, keep sample_valid=1 and leave overrun unchanged.
REQ-021 overrun SHALL stay set until reset.
REQ-022 A window clip flag SHALL set on any accepted code equal to 0 or 255; at completion it SHALL be copied, including the final sample's contribution, to the clip output, then cleared.
REQ-023 Direction tracking, per accepted sample: code>prev is UP; code<prev is DOWN; code==prev is FLAT; prev SHALL be updated to code.
REQ-024 Run counter: UP or DOWN equal to the previous direction SHALL increment it, saturating at OVL_RUN; UP or DOWN that differs SHALL set it to 1; FLAT SHALL clear it to 0 and set the previous direction to FLAT.
REQ-025 The first accepted sample after reset SHALL only load prev, with run and direction unchanged.
REQ-026 overload SHALL be asserted exactly while the run counter is at least OVL_RUN.

Reset
REQ-027 While rst_n=0, regardless of clk: sample=0, sample_valid=0, clip=0, overload=0, overrun=0, accumulator=0, counter=0, run=0, direction=FLAT, prev marked invalid.
REQ-028 Reset asserted mid-window SHALL discard the partial window; the first window after release SHALL start with the first accepted sample.

Verification (DECIM_LOG2=4, OVL_RUN=8)
REQ-029 The bench SHALL apply 16 consecutive en cycles of code=100 -> sample=100 and sample_valid=1 in the cycle after the 16th edge; clip=0 and overload=0.
REQ-030 The bench SHALL apply a ramp of code 0..15, one per cycle -> sample=7 (120>>4) with clip=1; overload SHALL rise after the 9th sample (code=8) and stay high.
REQ-031 The bench SHALL send 32 samples of code=50 followed by 16 of code=60 with sample_ack held low throughout -> overrun=1 after the second completion and sample=60 after the third; sample_valid stays high.
REQ-032 The bench SHALL pulse sample_ack on the exact edge of the second completion -> new sample loaded, sample_valid stays 1, overrun stays 0; an ack on the next cycle drops sample_valid.
REQ-033 The bench SHALL apply 10 samples of code=255, assert rst_n=0 for one cycle, then apply 16 samples of code=200 -> sample=200, clip=0, overrun=0.
REQ-034 The bench SHALL interleave en=0 gaps of random length in a 16-sample window of code=30 -> sample=30, with completion on the 16th en=1 edge only.
